// File: rtl/rom_dl_sdram_bridge.sv
// rom_dl_sdram_bridge
//   Buffers ROM-download byte strobes from data_io in a small FIFO and issues
//   them to SDRAM port1 as write requests on a toggle req/ack handshake.
//   It also produces a rom_loaded level once the download has ended and
//   every buffered byte has been written.
//
// Ports
//   clk_sys, res_n         system clock, asynchronous active-low reset
//   ioctl_download         download in progress
//   ioctl_wr/addr/dout     one-cycle byte write strobe with byte address and data
//   port_req / port_ack    toggle handshake to the sdram controller
//   port_a/ds/d/we         word address, byte enables {odd, even}, data, write enable
//   busy                   FIFO, staging register or request still occupied
//   rom_loaded             download ended and everything drained
//   err_overflow           sticky: strobe dropped because the FIFO was full
//   err_timeout            sticky: no ack within ACK_TIMEOUT cycles
//
// Build option
//   DL_WORD_MERGE_EN: stage an even byte and merge it with a following odd
//   byte of the same word into one 16-bit write.
//
// FSM states
//   state  | meaning
//   S_IDLE | no request outstanding; issue FIFO head if present
//   S_WAIT | request issued; wait for port_ack to match port_req or time out
module rom_dl_sdram_bridge #(
  parameter int DEPTH_LOG2  = 2,
  parameter int ADDR_W      = 23,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clk_sys,
  input  logic              res_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              port_req,
  input  logic              port_ack,
  output logic [ADDR_W-2:0] port_a,
  output logic [1:0]        port_ds,
  output logic [15:0]       port_d,
  output logic              port_we,
  output logic              busy,
  output logic              rom_loaded,
  output logic              err_overflow,
  output logic              err_timeout
);
  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [7:0]            TMO      = 8'(ACK_TIMEOUT);

  typedef struct packed {
    logic [ADDR_W-2:0] a;
    logic [1:0]        ds;
    logic [15:0]       d;
  } entry_t;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  function automatic entry_t mk_entry(input logic [ADDR_W-1:0] addr, input logic [7:0] data);
    entry_t e;
    e.a  = addr[ADDR_W-1:1];
    e.ds = addr[0] ? 2'b10 : 2'b01;
    e.d  = {data, data};
    return e;
  endfunction

  state_t                state_q, state_d;
  entry_t                mem_q [DEPTH];
  entry_t                mem_d [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [7:0]            tmo_q, tmo_d;
  logic                  req_q, req_d;
  logic                  ack_inv_q, ack_inv_d;
  entry_t                out_q, out_d;
  logic                  rom_loaded_q, rom_loaded_d;
  logic                  err_ovf_q, err_ovf_d;
  logic                  err_tmo_q, err_tmo_d;

  logic   empty, full, pop, push, do_push, staged;
  entry_t push_entry;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);
  assign pop   = (state_q == S_IDLE) && !empty;

`ifdef DL_WORD_MERGE_EN
  logic              stg_v_q, stg_v_d;
  logic [ADDR_W-1:0] stg_a_q, stg_a_d;
  logic [7:0]        stg_b_q, stg_b_d;

  assign staged = stg_v_q;

  // A staged byte is normally even. If a non-consecutive strobe arrives it
  // displaces the staged byte into the FIFO and takes the slot itself, even
  // when odd, so at most one push happens per cycle.
  always_comb begin
    push       = 1'b0;
    push_entry = mk_entry(stg_a_q, stg_b_q);
    stg_v_d    = stg_v_q;
    stg_a_d    = stg_a_q;
    stg_b_d    = stg_b_q;
    if (ioctl_wr) begin
      if (stg_v_q && !stg_a_q[0] && ioctl_addr[0] &&
          ({ioctl_addr[ADDR_W-1:1], 1'b0} == stg_a_q)) begin
        push          = 1'b1;
        push_entry.ds = 2'b11;
        push_entry.d  = {ioctl_dout, stg_b_q};
        stg_v_d       = 1'b0;
      end else if (stg_v_q || !ioctl_addr[0]) begin
        push    = stg_v_q;
        stg_v_d = 1'b1;
        stg_a_d = ioctl_addr;
        stg_b_d = ioctl_dout;
      end else begin
        push       = 1'b1;
        push_entry = mk_entry(ioctl_addr, ioctl_dout);
      end
    end else if (stg_v_q && !ioctl_download && (!full || pop)) begin
      push    = 1'b1;
      stg_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      stg_v_q <= 1'b0;
      stg_a_q <= '0;
      stg_b_q <= '0;
    end else begin
      stg_v_q <= stg_v_d;
      stg_a_q <= stg_a_d;
      stg_b_q <= stg_b_d;
    end
  end
`else
  assign staged = 1'b0;

  always_comb begin
    push       = ioctl_wr;
    push_entry = mk_entry(ioctl_addr, ioctl_dout);
  end
`endif

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_ovf_d = err_ovf_q;
    do_push   = push && (!full || pop);
    if (push && !do_push) err_ovf_d = 1'b1;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // After a timeout ack_inv flips so the missing ack is treated as received
  // and the next request's parity lines up with the controller's.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    out_d     = out_q;
    tmo_d     = tmo_q;
    ack_inv_d = ack_inv_q;
    err_tmo_d = err_tmo_q;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          out_d   = mem_q[rd_ptr_q];
          req_d   = ~req_q;
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if ((port_ack ^ ack_inv_q) == req_q) begin
          state_d = S_IDLE;
        end else if (tmo_q == TMO) begin
          err_tmo_d = 1'b1;
          ack_inv_d = ~ack_inv_q;
          state_d   = S_IDLE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rom_loaded_d = rom_loaded_q;
    if (ioctl_download)
      rom_loaded_d = 1'b0;
    else if (empty && (state_q == S_IDLE) && !staged)
      rom_loaded_d = 1'b1;
  end

  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      state_q      <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      tmo_q        <= '0;
      req_q        <= 1'b0;
      ack_inv_q    <= 1'b0;
      out_q        <= '0;
      rom_loaded_q <= 1'b0;
      err_ovf_q    <= 1'b0;
      err_tmo_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      tmo_q        <= tmo_d;
      req_q        <= req_d;
      ack_inv_q    <= ack_inv_d;
      out_q        <= out_d;
      rom_loaded_q <= rom_loaded_d;
      err_ovf_q    <= err_ovf_d;
      err_tmo_q    <= err_tmo_d;
    end
  end

  assign port_req     = req_q;
  assign port_a       = out_q.a;
  assign port_ds      = out_q.ds;
  assign port_d       = out_q.d;
  assign port_we      = !empty || (state_q == S_WAIT);
  assign busy         = port_we || staged;
  assign rom_loaded   = rom_loaded_q;
  assign err_overflow = err_ovf_q;
  assign err_timeout  = err_tmo_q;
endmodule

// File: tb/tb_rom_dl_sdram_bridge.sv
module tb_rom_dl_sdram_bridge;
  logic        clk_sys = 1'b0;
  logic        res_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [22:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        port_req, port_ack, port_we, busy, rom_loaded, err_overflow, err_timeout;
  logic [21:0] port_a;
  logic [1:0]  port_ds;
  logic [15:0] port_d;

  int n_tests = 0;
  int n_fail = 0;

  rom_dl_sdram_bridge dut (
    .clk_sys(clk_sys), .res_n(res_n), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .port_req(port_req), .port_ack(port_ack), .port_a(port_a), .port_ds(port_ds),
    .port_d(port_d), .port_we(port_we), .busy(busy), .rom_loaded(rom_loaded),
    .err_overflow(err_overflow), .err_timeout(err_timeout)
  );

  always #5 clk_sys = ~clk_sys;

  // Controller model: echoes port_req back on port_ack a few cycles later.
  logic       ack_en = 1'b1;
  logic [1:0] req_pipe;
  always @(posedge clk_sys) begin
    if (!res_n) begin
      req_pipe <= '0;
      port_ack <= 1'b0;
    end else begin
      req_pipe <= {req_pipe[0], port_req};
      if (ack_en) port_ack <= req_pipe[1];
    end
  end

  // Request monitor: records every port_req toggle with the bus contents.
  typedef struct {
    logic [21:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
    time         t;
  } tog_t;
  tog_t tog_q[$];
  logic req_prev = 1'b0;
  always @(posedge clk_sys) begin
    tog_t r;
    #1;
    if (port_req !== req_prev) begin
      r.a = port_a; r.ds = port_ds; r.d = port_d; r.t = $time;
      tog_q.push_back(r);
    end
    req_prev = port_req;
  end

  task automatic do_reset();
    @(negedge clk_sys);
    res_n = 1'b0; ioctl_wr = 1'b0; ioctl_download = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; ack_en = 1'b1;
    repeat (3) @(negedge clk_sys);
    res_n = 1'b1;
    tog_q.delete();
  endtask

  task automatic wait_tog(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (tog_q.size() >= n) begin ok = 1'b1; break; end
      @(negedge clk_sys);
    end
  endtask

  task automatic strobe(input logic [22:0] a, input logic [7:0] d);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
  endtask

  task automatic test_reset();
    @(negedge clk_sys);
    res_n = 1'b0;
    #1;
    n_tests++; if (port_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", port_req); end
    n_tests++; if (busy !== 1'b0 || port_we !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b/%b exp=0/0", busy, port_we); end
    n_tests++; if (rom_loaded !== 1'b0) begin n_fail++; $display("FAIL reset_rom_loaded got=%b exp=0", rom_loaded); end
    n_tests++; if ({err_overflow, err_timeout} !== 2'b00) begin n_fail++; $display("FAIL reset_err got=%b%b exp=00", err_overflow, err_timeout); end
    n_tests++; if ({port_a, port_ds, port_d} !== '0) begin n_fail++; $display("FAIL reset_bus got=%h/%b/%h exp=0", port_a, port_ds, port_d); end
    do_reset();
    repeat (2) @(negedge clk_sys);
    n_tests++; if (rom_loaded !== 1'b1) begin n_fail++; $display("FAIL idle_rom_loaded got=%b exp=1", rom_loaded); end
  endtask

  task automatic test_basic_writes();
    logic [21:0] exp_a  [4] = '{22'd0, 22'd0, 22'd1, 22'd1};
    logic [1:0]  exp_ds [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [15:0] exp_d  [4] = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    logic [7:0]  bytes  [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    time t_s;
    bit ok;
    do_reset();
    ioctl_download = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      if (i == 0) t_s = $time;
      strobe(23'(i), bytes[i]);
    end
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    wait_tog(4, 100, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL basic_toggles got=%0d exp=4", tog_q.size()); end
    if (ok) begin
      // strobe set at a negedge; toggle seen 1ns after the 2nd following posedge
      n_tests++; if (tog_q[0].t - t_s !== 16) begin n_fail++; $display("FAIL basic_latency got=%0t exp=16", tog_q[0].t - t_s); end
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (tog_q[i].a !== exp_a[i] || tog_q[i].ds !== exp_ds[i] || tog_q[i].d !== exp_d[i]) begin
          n_fail++;
          $display("FAIL basic_req%0d got=%h/%b/%h exp=%h/%b/%h", i, tog_q[i].a, tog_q[i].ds, tog_q[i].d, exp_a[i], exp_ds[i], exp_d[i]);
        end
      end
    end
    ioctl_download = 1'b0;
    repeat (20) @(negedge clk_sys);
    n_tests++; if (rom_loaded !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_done got=%b/%b exp=1/0", rom_loaded, busy); end
    n_tests++; if ({err_overflow, err_timeout} !== 2'b00) begin n_fail++; $display("FAIL basic_err got=%b%b exp=00", err_overflow, err_timeout); end
  endtask

  task automatic test_overflow();
    bit ok;
    do_reset();
    ioctl_download = 1'b1;
    ack_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_sys);
      strobe(23'h10 + 23'(i), 8'(i + 1));
    end
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    n_tests++; if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_five got=%b exp=0", err_overflow); end
    n_tests++; if (tog_q.size() !== 1 || busy !== 1'b1) begin n_fail++; $display("FAIL ovf_inflight got=%0d/%b exp=1/1", tog_q.size(), busy); end
    // ack returns at the next posedge; WAIT->IDLE one edge later; pop the edge after
    ack_en = 1'b1;
    repeat (2) @(negedge clk_sys);
    strobe(23'h15, 8'h06);
    @(negedge clk_sys);
    ack_en = 1'b0;
    n_tests++; if (err_overflow !== 1'b0 || tog_q.size() !== 2) begin n_fail++; $display("FAIL ovf_push_pop got=%b/%0d exp=0/2", err_overflow, tog_q.size()); end
    strobe(23'h16, 8'h07);
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    n_tests++; if (err_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sixth got=%b exp=1", err_overflow); end
    ack_en = 1'b1;
    wait_tog(6, 200, ok);
    repeat (30) @(negedge clk_sys);
    n_tests++; if (tog_q.size() !== 6) begin n_fail++; $display("FAIL ovf_count got=%0d exp=6", tog_q.size()); end
    if (tog_q.size() >= 6) begin
      n_tests++; if (tog_q[4].a !== 22'h0A || tog_q[4].ds !== 2'b01 || tog_q[4].d !== 16'h0505) begin n_fail++; $display("FAIL ovf_req4 got=%h/%b/%h exp=00000a/01/0505", tog_q[4].a, tog_q[4].ds, tog_q[4].d); end
      n_tests++; if (tog_q[5].a !== 22'h0A || tog_q[5].ds !== 2'b10 || tog_q[5].d !== 16'h0606) begin n_fail++; $display("FAIL ovf_req5 got=%h/%b/%h exp=00000a/10/0606", tog_q[5].a, tog_q[5].ds, tog_q[5].d); end
    end
    n_tests++; if (busy !== 1'b0 || err_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_end got=%b/%b exp=0/1", busy, err_overflow); end
  endtask

  task automatic test_timeout();
    bit ok;
    int k;
    do_reset();
    ioctl_download = 1'b1;
    ack_en = 1'b0;
    @(negedge clk_sys); strobe(23'h20, 8'h11);
    @(negedge clk_sys); strobe(23'h21, 8'h22);
    @(negedge clk_sys); ioctl_wr = 1'b0;
    wait_tog(1, 10, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL tmo_first got=%0d exp=1", tog_q.size()); end
    k = 0;
    while (err_timeout !== 1'b1 && k < 400) begin
      @(negedge clk_sys);
      k++;
    end
    n_tests++; if (k < 255 || k > 257) begin n_fail++; $display("FAIL tmo_cycles got=%0d exp=255..257", k); end
    wait_tog(2, 5, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL tmo_next got=%0d exp=2", tog_q.size()); end
    if (ok) begin
      n_tests++; if (tog_q[1].a !== 22'h10 || tog_q[1].ds !== 2'b10 || tog_q[1].d !== 16'h2222) begin n_fail++; $display("FAIL tmo_req1 got=%h/%b/%h exp=000010/10/2222", tog_q[1].a, tog_q[1].ds, tog_q[1].d); end
    end
    repeat (3) @(negedge clk_sys);
    n_tests++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky got=%b exp=1", err_timeout); end
  endtask

  task automatic test_rom_loaded();
    int k;
    bit early;
    do_reset();
    repeat (2) @(negedge clk_sys);
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    n_tests++; if (rom_loaded !== 1'b0) begin n_fail++; $display("FAIL rl_dl_rise got=%b exp=0", rom_loaded); end
    ack_en = 1'b0;
    strobe(23'h30, 8'h44);
    @(negedge clk_sys); strobe(23'h31, 8'h55);
    @(negedge clk_sys); ioctl_wr = 1'b0; ioctl_download = 1'b0;
    early = 1'b0;
    repeat (10) begin
      @(negedge clk_sys);
      if (rom_loaded !== 1'b0) early = 1'b1;
    end
    n_tests++; if (early) begin n_fail++; $display("FAIL rl_early got=1 exp=0"); end
    ack_en = 1'b1;
    k = 0;
    while (rom_loaded !== 1'b1 && k < 100) begin
      @(negedge clk_sys);
      k++;
    end
    n_tests++; if (rom_loaded !== 1'b1) begin n_fail++; $display("FAIL rl_rise got=%b exp=1", rom_loaded); end
    n_tests++; if (tog_q.size() !== 2 || port_ack !== port_req || busy !== 1'b0) begin n_fail++; $display("FAIL rl_drained got=%0d/%b/%b exp=2/match/0", tog_q.size(), port_ack ^ port_req, busy); end
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    n_tests++; if (rom_loaded !== 1'b0) begin n_fail++; $display("FAIL rl_restart got=%b exp=0", rom_loaded); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    ioctl_download = 1'b1;
    ack_en = 1'b0;
    @(negedge clk_sys); strobe(23'h41, 8'h77);
    @(negedge clk_sys); ioctl_wr = 1'b0;
    repeat (4) @(negedge clk_sys);
    n_tests++; if (port_req !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL mid_wait got=%b/%b exp=1/1", port_req, busy); end
    res_n = 1'b0;
    #1;
    n_tests++; if ({port_req, busy, rom_loaded, port_we} !== 4'b0000) begin n_fail++; $display("FAIL mid_reset got=%b%b%b%b exp=0000", port_req, busy, rom_loaded, port_we); end
    @(negedge clk_sys);
    res_n = 1'b1;
  endtask

`ifdef DL_WORD_MERGE_EN
  task automatic test_merge();
    bit ok;
    do_reset();
    ioctl_download = 1'b1;
    @(negedge clk_sys); strobe(23'h10, 8'h11);
    @(negedge clk_sys); strobe(23'h11, 8'h22);
    @(negedge clk_sys); strobe(23'h14, 8'h33);
    @(negedge clk_sys); ioctl_wr = 1'b0; ioctl_download = 1'b0;
    wait_tog(2, 50, ok);
    repeat (20) @(negedge clk_sys);
    n_tests++; if (tog_q.size() !== 2) begin n_fail++; $display("FAIL merge_count got=%0d exp=2", tog_q.size()); end
    if (tog_q.size() >= 2) begin
      n_tests++; if (tog_q[0].a !== 22'h08 || tog_q[0].ds !== 2'b11 || tog_q[0].d !== 16'h2211) begin n_fail++; $display("FAIL merge_req0 got=%h/%b/%h exp=000008/11/2211", tog_q[0].a, tog_q[0].ds, tog_q[0].d); end
      n_tests++; if (tog_q[1].a !== 22'h0A || tog_q[1].ds !== 2'b01 || tog_q[1].d !== 16'h3333) begin n_fail++; $display("FAIL merge_req1 got=%h/%b/%h exp=00000a/01/3333", tog_q[1].a, tog_q[1].ds, tog_q[1].d); end
    end
    n_tests++; if (rom_loaded !== 1'b1) begin n_fail++; $display("FAIL merge_loaded got=%b exp=1", rom_loaded); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef DL_WORD_MERGE_EN
    test_merge();
`else
    test_basic_writes();
    test_overflow();
    test_timeout();
    test_rom_loaded();
`endif
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
